// File: rtl/calc_display_ctrl.sv
// -----------------------------------------------------------------------------
// calc_display_ctrl
//
// Display back end for the calculator core. Digits streamed by the core while
// it is printing are collected in a shadow buffer. When printing ends, the
// shadow buffer is copied into the active buffer in one step, so the display
// never shows a partly written frame. The active buffer is shown on eight
// multiplexed seven-segment digits. The driver adds leading-zero blanking, an
// "Erro" override while the core reports an error, and a busy decimal point.
//
// Ports:
//   clock     in   1  system clock
//   reset     in   1  synchronous, active-high reset
//   status    in   2  core status: 00 error, 01 busy, 10 ready, 11 printing
//   data      in   4  digit value for position pos-1 while printing
//   pos       in   4  core position counter (1..8 valid while printing)
//   an        out  8  one-hot digit enables, an[0] = least significant digit
//   seg       out  7  segments {g,f,e,d,c,b,a}
//   dp        out  1  decimal point
//   commit    out  1  one-cycle pulse after the active buffer is refreshed
//   scan_idx  out  3  digit currently being scanned (debug)
// -----------------------------------------------------------------------------
module calc_display_ctrl #(
    parameter int REFRESH_DIV    = 50000,
    parameter bit BLANK_LZ       = 1'b1,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] status,
    input  logic [3:0] data,
    input  logic [3:0] pos,
    output logic [7:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       commit,
    output logic [2:0] scan_idx
);

    localparam logic [1:0] ST_ERROR = 2'b00;
    localparam logic [1:0] ST_BUSY  = 2'b01;
    localparam logic [1:0] ST_READY = 2'b10;
    localparam logic [1:0] ST_PRINT = 2'b11;

    localparam int              CNT_W    = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

    // Inactive levels; XOR with these converts active-high codes to pin levels.
    localparam logic [7:0] AN_OFF  = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic       DP_OFF  = SEG_ACTIVE_LOW ? 1'b1  : 1'b0;

    localparam logic [6:0] GLYPH_E     = 7'h79;
    localparam logic [6:0] GLYPH_R     = 7'h50;
    localparam logic [6:0] GLYPH_O     = 7'h5C;
    localparam logic [6:0] GLYPH_BLANK = 7'h00;

    // Active-high segment code for a stored digit; 4'hF is the '-' marker.
    function automatic logic [6:0] digit_glyph(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'd0:    g = 7'h3F;
            4'd1:    g = 7'h06;
            4'd2:    g = 7'h5B;
            4'd3:    g = 7'h4F;
            4'd4:    g = 7'h66;
            4'd5:    g = 7'h6D;
            4'd6:    g = 7'h7D;
            4'd7:    g = 7'h07;
            4'd8:    g = 7'h7F;
            4'd9:    g = 7'h6F;
            4'hF:    g = 7'h40;
            default: g = 7'h00;
        endcase
        return g;
    endfunction

    logic [3:0] shadow_r [8];
    logic [3:0] active_r [8];
    logic [3:0] shadow_next_s [8];
    logic [1:0] prev_status_r;
    logic       commit_r;
    logic [CNT_W-1:0] cnt_r;
    logic [2:0] scan_idx_r;
    logic [7:0] an_r;
    logic [6:0] seg_r;
    logic       dp_r;

    logic       cap_hit_s;
    logic [2:0] cap_idx_s;
    logic [3:0] cap_val_s;
    logic       commit_cond_s;
    logic [7:0] blank_s;
    logic       run_zero_s;
    logic [6:0] glyph_s;
    logic       dp_on_s;
    logic [7:0] an_on_s;

    // Capture decode: position 1..8 maps to buffer slot 0..7.
    always_comb begin
        cap_hit_s     = (status == ST_PRINT) && (pos >= 4'd1) && (pos <= 4'd8);
        cap_idx_s     = pos[2:0] - 3'd1;
        cap_val_s     = (data <= 4'd9) ? data : 4'hF;
        commit_cond_s = (status == ST_READY) && (prev_status_r == ST_PRINT);
    end

    // Shadow contents after this cycle's write, also used to forward into a commit.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            shadow_next_s[i] = (cap_hit_s && (cap_idx_s == 3'(i))) ? cap_val_s : shadow_r[i];
        end
    end

    // Frame assembly, commit to the active buffer and status history.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                shadow_r[i] <= 4'd0;
                active_r[i] <= 4'd0;
            end
            prev_status_r <= ST_READY;
            commit_r      <= 1'b0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                shadow_r[i] <= shadow_next_s[i];
                active_r[i] <= commit_cond_s ? shadow_next_s[i] : active_r[i];
            end
            prev_status_r <= status;
            commit_r      <= commit_cond_s;
        end
    end

    // Refresh timer and scan position.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_r      <= '0;
            scan_idx_r <= 3'd0;
        end else if (cnt_r == CNT_MAX) begin
            cnt_r      <= '0;
            scan_idx_r <= scan_idx_r + 3'd1;
        end else begin
            cnt_r      <= cnt_r + CNT_W'(1);
            scan_idx_r <= scan_idx_r;
        end
    end

    // Leading-zero map: a digit is blank when it and every more significant digit are zero.
    always_comb begin
        run_zero_s = 1'b1;
        blank_s    = 8'h00;
        for (int i = 7; i >= 1; i--) begin
            run_zero_s = run_zero_s && (active_r[i] == 4'd0);
            blank_s[i] = run_zero_s;
        end
    end

    // Glyph selection for the digit being scanned, including status overrides.
    always_comb begin
        glyph_s = GLYPH_BLANK;
        if (status == ST_ERROR) begin
            case (scan_idx_r)
                3'd3:        glyph_s = GLYPH_E;
                3'd2, 3'd1:  glyph_s = GLYPH_R;
                3'd0:        glyph_s = GLYPH_O;
                default:     glyph_s = GLYPH_BLANK;
            endcase
        end else if (BLANK_LZ && blank_s[scan_idx_r]) begin
            glyph_s = GLYPH_BLANK;
        end else begin
            glyph_s = digit_glyph(active_r[scan_idx_r]);
        end
        dp_on_s = (status == ST_BUSY) && (scan_idx_r == 3'd0);
        an_on_s = 8'h01 << scan_idx_r;
    end

    // Registered pin drivers at the configured polarity.
    always_ff @(posedge clock) begin
        if (reset) begin
            an_r  <= AN_OFF;
            seg_r <= SEG_OFF;
            dp_r  <= DP_OFF;
        end else begin
            an_r  <= an_on_s ^ AN_OFF;
            seg_r <= glyph_s ^ SEG_OFF;
            dp_r  <= dp_on_s ^ DP_OFF;
        end
    end

    assign an       = an_r;
    assign seg      = seg_r;
    assign dp       = dp_r;
    assign commit   = commit_r;
    assign scan_idx = scan_idx_r;

endmodule
